if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, giving the PC loaded on reset (bit 0 forced to 0).
REQ-002 SHALL have parameter HALT_NIBBLE, default 4'hF; a fetched instruction with bits [15:12] equal to it is a HALT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port imem_addr, output, 16 bits: byte address driven to the combinational instruction memory.
REQ-006 SHALL have port imem_data, input, 16 bits: instruction returned by the memory in the same cycle.
REQ-007 SHALL have port stall, input, 1 bit: decode cannot accept; hold all state.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch/jump taken; redirect the PC.
REQ-009 SHALL have port redirect_pc, input, 16 bits: redirect target byte address.
REQ-010 SHALL have port ifid_valid, output, 1 bit: the IF/ID register holds a valid instruction.
REQ-011 SHALL have port ifid_instr, output, 16 bits: registered instruction.
REQ-012 SHALL have port ifid_pc, output, 16 bits: byte address of ifid_instr.
REQ-013 SHALL have port ifid_pc_plus2, output, 16 bits: ifid_pc + 2, modulo 2^16.
REQ-014 SHALL have port halted, output, 1 bit: high while the FSM is in HALTED.

Function
REQ-015 SHALL drive imem_addr combinationally from the PC register; bit 0 is always 0.
REQ-016 SHALL implement FSM states BOOT, RUN and HALTED.
REQ-017 BOOT SHALL last exactly one cycle after rst deasserts, fetch nothing, keep ifid_valid=0, then go to RUN.
REQ-018 In RUN with stall=0 and redirect_valid=0, each cycle SHALL load ifid_instr<=imem_data, ifid_pc<=pc, ifid_valid<=1, pc<=pc+2.
REQ-019 PC increment SHALL wrap 16'hFFFE -> 16'h0000 with no flag.
REQ-020 With stall=1 and redirect_valid=0, SHALL hold pc, FSM state and all ifid_* outputs.
REQ-021 redirect_valid=1 SHALL take priority over stall and HALT in any state except BOOT: pc<=redirect_pc & 16'hFFFE, ifid_valid<=0 (one bubble), state<=RUN.
REQ-022 redirect_valid during BOOT SHALL be applied as in REQ-021, and BOOT still exits to RUN.
REQ-023 When a HALT is loaded per REQ-018, the HALT instruction SHALL be delivered (ifid_valid=1), pc SHALL NOT increment, and state SHALL become HALTED.
REQ-024 In HALTED with stall=0, SHALL set ifid_valid<=0 and hold pc; with stall=1, SHALL hold everything.
REQ-025 Fetch latency SHALL be one cycle: the address presented in cycle N appears on ifid_instr after edge N+1.

Reset
REQ-026 On rst=1 at a clock edge: pc<=RESET_PC, state<=BOOT, ifid_valid<=0, ifid_instr<=0, ifid_pc<=0, ifid_pc_plus2<=2, halted<=0.
REQ-027 rst SHALL override stall and redirect_valid, including in the middle of a stall or while halted.

Configuration
REQ-028 With macro IF_STAGE_FETCH_COUNT_EN defined, SHALL add output fetch_count (16 bits), reset to 0, which increments on every ifid_valid<=1 load and saturates at 16'hFFFF.
REQ-029 Without IF_STAGE_FETCH_COUNT_EN, fetch_count SHALL be absent and all other behaviour SHALL be identical.

Verification (memory model: imem_data = imem_addr>>1, except where overridden)
REQ-030 Reset, then 4 free-running cycles -> BOOT gives ifid_valid=0; the next edges give ifid_pc 0,2,4 with ifid_instr 0,1,2.
REQ-031 Stall held for 3 cycles while ifid_pc=16'h0004 -> ifid_pc/ifid_instr stay 4/2 and imem_addr stays 6; after release, ifid_pc=6.
REQ-032 redirect_valid=1 with redirect_pc=16'h0031 and stall=1 -> next cycle ifid_valid=0 and imem_addr=16'h0030; the cycle after, ifid_instr=24.
REQ-033 PC at 16'hFFFE -> ifid_pc=16'hFFFE, ifid_pc_plus2=16'h0000, next imem_addr=16'h0000.
REQ-034 Memory returns 16'hF123 at address 16'h0010 -> ifid_instr=16'hF123 with valid=1, then halted=1 and ifid_valid=0 with imem_addr stuck at 16'h0010; a redirect to 16'h0000 resumes fetch.
REQ-035 rst asserted during a stall and again while HALTED -> all REQ-026 values appear after the edge; with IF_STAGE_FETCH_COUNT_EN defined, fetch_count=0 and then counts 1,2,3.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage for a 16-bit pipeline.
//
// Holds the program counter, drives it to a combinational instruction memory
// and registers the returned word into the IF/ID pipeline register. A small
// FSM (BOOT -> RUN -> HALTED) spends one idle cycle after reset, then fetches
// one instruction per cycle. It stops after delivering a HALT instruction,
// which is any word whose top nibble equals HALT_NIBBLE. A redirect from a
// later stage overrides stall and HALT and costs one bubble.
//
// Parameters
//   RESET_PC      PC loaded on reset (bit 0 forced to 0)
//   HALT_NIBBLE   instr[15:12] value that marks a HALT
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   imem_addr       byte address to instruction memory (bit 0 always 0)
//   imem_data       instruction returned in the same cycle
//   stall           decode cannot accept; hold everything
//   redirect_valid  branch/jump taken; load redirect_pc
//   redirect_pc     redirect target byte address
//   ifid_valid      IF/ID register holds a valid instruction
//   ifid_instr      registered instruction
//   ifid_pc         byte address of ifid_instr
//   ifid_pc_plus2   ifid_pc + 2 (mod 2^16)
//   halted          high while the FSM is in HALTED
//   fetch_count     (only with IF_STAGE_FETCH_COUNT_EN) saturating count of
//                   instructions delivered since reset
//
// Optional feature macro: IF_STAGE_FETCH_COUNT_EN
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_NIBBLE = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        ifid_valid,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic [15:0] ifid_pc_plus2,
`ifdef IF_STAGE_FETCH_COUNT_EN
   output logic [15:0] fetch_count,
`endif
   output logic        halted
);

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]  state;
   logic [15:0] pc;
   logic        is_halt;
   logic        fetch_load;

   assign is_halt = (imem_data[15:12] == HALT_NIBBLE);

   // A fetch is latched into IF/ID only in RUN, not stalled, not redirected.
   assign fetch_load = !redirect_valid && (state == ST_RUN) && !stall;

   assign imem_addr     = {pc[15:1], 1'b0};
   assign ifid_pc_plus2 = ifid_pc + 16'd2;
   assign halted        = (state == ST_HALTED);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC & 16'hFFFE;
         state      <= ST_BOOT;
         ifid_valid <= 1'b0;
         ifid_instr <= 16'h0000;
         ifid_pc    <= 16'h0000;
      end else if (redirect_valid) begin
         // Redirect wins over stall and HALT; the stale IF/ID word becomes
         // a bubble and fetch restarts at the target next cycle.
         pc         <= redirect_pc & 16'hFFFE;
         ifid_valid <= 1'b0;
         state      <= ST_RUN;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (fetch_load) begin
                  ifid_instr <= imem_data;
                  ifid_pc    <= pc;
                  ifid_valid <= 1'b1;
                  // A HALT is delivered but the PC stays on it.
                  if (is_halt) begin
                     state <= ST_HALTED;
                  end else begin
                     pc <= pc + 16'd2;
                  end
               end
            end
            ST_HALTED: begin
               if (!stall) begin
                  ifid_valid <= 1'b0;
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

`ifdef IF_STAGE_FETCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= 16'h0000;
      end else if (fetch_load && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- scoreboard bench for if_stage.
// The driver issues one set of inputs per cycle, advances a reference model
// of the fetch stage and queues the expected post-edge outputs. The monitor
// pops one entry after every rising edge and compares it with the DUT.
// Memory model: imem_data = imem_addr >> 1, except for a few HALT overrides.
// ---------------------------------------------------------------------------
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_pc_plus2;
   logic        halted;
`ifdef IF_STAGE_FETCH_COUNT_EN
   logic [15:0] fetch_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] ovr [logic [15:0]];

   function automatic logic [15:0] mem_read(input logic [15:0] a);
      if (ovr.exists(a)) return ovr[a];
      return a >> 1;
   endfunction

   assign imem_data = mem_read(imem_addr);

   if_stage #(.RESET_PC(16'h0000), .HALT_NIBBLE(4'hF)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifid_valid     (ifid_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .ifid_pc_plus2  (ifid_pc_plus2),
`ifdef IF_STAGE_FETCH_COUNT_EN
      .fetch_count    (fetch_count),
`endif
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        valid;
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] plus2;
      logic        halted;
      logic [15:0] addr;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];

   // Model view: next fetch address, whether the idle boot cycle is pending,
   // whether fetching has stopped on a HALT, and the last delivered word.
   logic [15:0] m_fetch_addr;
   bit          m_boot_pending;
   bit          m_stopped;
   logic        m_valid;
   logic [15:0] m_instr;
   logic [15:0] m_ipc;
   int          m_cnt;

   task automatic model_step(input logic r, input logic s, input logic rv, input logic [15:0] rp);
      logic [15:0] w;
      if (r) begin
         m_fetch_addr   = 16'h0000;
         m_boot_pending = 1;
         m_stopped      = 0;
         m_valid        = 0;
         m_instr        = 16'h0000;
         m_ipc          = 16'h0000;
         m_cnt          = 0;
      end else if (rv) begin
         m_fetch_addr   = {rp[15:1], 1'b0};
         m_boot_pending = 0;
         m_stopped      = 0;
         m_valid        = 0;
      end else if (m_boot_pending) begin
         m_boot_pending = 0;
      end else if (m_stopped) begin
         if (!s) m_valid = 0;
      end else if (!s) begin
         w       = mem_read(m_fetch_addr);
         m_instr = w;
         m_ipc   = m_fetch_addr;
         m_valid = 1;
         if (m_cnt < 65535) m_cnt++;
         if (w[15:12] == 4'hF) m_stopped = 1;
         else m_fetch_addr = 16'((int'(m_fetch_addr) + 2) % 65536);
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic rv, input logic [15:0] rp);
      exp_t e;
      @(negedge clk);
      rst            = r;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rp;
      model_step(r, s, rv, rp);
      e.valid  = m_valid;
      e.instr  = m_instr;
      e.pc     = m_ipc;
      e.plus2  = 16'((int'(m_ipc) + 2) % 65536);
      e.halted = m_stopped;
      e.addr   = m_fetch_addr;
      e.cnt    = 16'(m_cnt);
      q.push_back(e);
   endtask

   task automatic peek();
      @(posedge clk);
      #2;
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_valid",  {15'd0, ifid_valid}, {15'd0, e.valid});
            check("sb_instr",  ifid_instr,          e.instr);
            check("sb_pc",     ifid_pc,             e.pc);
            check("sb_plus2",  ifid_pc_plus2,       e.plus2);
            check("sb_halted", {15'd0, halted},     {15'd0, e.halted});
            check("sb_addr",   imem_addr,           e.addr);
`ifdef IF_STAGE_FETCH_COUNT_EN
            check("sb_count",  fetch_count,         e.cnt);
`endif
         end
      end
   end

   // ---------------- driver ----------------
   initial begin
      int wait_cycles;
      ovr[16'h0010] = 16'hF123;
      ovr[16'h0020] = 16'hFABC;
      ovr[16'h003A] = 16'hF000;
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
      m_fetch_addr = 16'h0000; m_boot_pending = 1; m_stopped = 0;
      m_valid = 0; m_instr = 16'h0000; m_ipc = 16'h0000; m_cnt = 0;

      // Reset, boot, then sequential fetch 0,2,4.
      cycle(1, 0, 0, 16'h0000);
      cycle(1, 0, 0, 16'h0000);
      peek();
      check("rst_valid", {15'd0, ifid_valid}, 16'd0);
      check("rst_plus2", ifid_pc_plus2, 16'h0002);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("boot_valid", {15'd0, ifid_valid}, 16'd0);
      cycle(0, 0, 0, 16'h0000);
      cycle(0, 0, 0, 16'h0000);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("seq_pc", ifid_pc, 16'h0004);
      check("seq_instr", ifid_instr, 16'h0002);

      // Stall for three cycles, then release.
      repeat (3) cycle(0, 1, 0, 16'h0000);
      peek();
      check("stall_pc", ifid_pc, 16'h0004);
      check("stall_instr", ifid_instr, 16'h0002);
      check("stall_addr", imem_addr, 16'h0006);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("release_pc", ifid_pc, 16'h0006);

      // Redirect to an odd address while stalled.
      cycle(0, 1, 1, 16'h0031);
      peek();
      check("redir_valid", {15'd0, ifid_valid}, 16'd0);
      check("redir_addr", imem_addr, 16'h0030);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("redir_instr", ifid_instr, 16'd24);

      // PC wrap.
      cycle(0, 0, 1, 16'hFFFE);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("wrap_pc", ifid_pc, 16'hFFFE);
      check("wrap_plus2", ifid_pc_plus2, 16'h0000);
      check("wrap_addr", imem_addr, 16'h0000);

      // HALT at 0x10, then resume by redirect.
      cycle(0, 0, 1, 16'h0010);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("halt_instr", ifid_instr, 16'hF123);
      check("halt_valid", {15'd0, ifid_valid}, 16'd1);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("halted_flag", {15'd0, halted}, 16'd1);
      check("halted_valid", {15'd0, ifid_valid}, 16'd0);
      check("halted_addr", imem_addr, 16'h0010);
      cycle(0, 1, 0, 16'h0000);
      cycle(0, 0, 0, 16'h0000);
      cycle(0, 0, 1, 16'h0000);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("resume_valid", {15'd0, ifid_valid}, 16'd1);
      check("resume_pc", ifid_pc, 16'h0000);

      // Reset in the middle of a stall, then count fetches.
      cycle(0, 1, 0, 16'h0000);
      cycle(1, 1, 1, 16'h0055);
      peek();
      check("rst_stall_instr", ifid_instr, 16'h0000);
      check("rst_stall_pc", ifid_pc, 16'h0000);
      check("rst_stall_halted", {15'd0, halted}, 16'd0);
      cycle(0, 0, 0, 16'h0000);
      for (int i = 1; i <= 3; i++) begin
         cycle(0, 0, 0, 16'h0000);
         peek();
`ifdef IF_STAGE_FETCH_COUNT_EN
         check("count_seq", fetch_count, 16'(i));
`else
         check("count_seq_pc", ifid_pc, 16'(2 * (i - 1)));
`endif
      end

      // Reset while halted.
      cycle(0, 0, 1, 16'h0020);
      cycle(0, 0, 0, 16'h0000);
      cycle(0, 0, 0, 16'h0000);
      peek();
      check("pre_rst_halted", {15'd0, halted}, 16'd1);
      cycle(1, 1, 1, 16'h0100);
      peek();
      check("rst_halt_halted", {15'd0, halted}, 16'd0);
      check("rst_halt_addr", imem_addr, 16'h0000);
      check("rst_halt_instr", ifid_instr, 16'h0000);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic r, s, rv;
         logic [15:0] rp;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 25);
         rv = ($urandom_range(0, 99) < 8);
         rp = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
         cycle(r, s, rv, rp);
      end

      // Drain the scoreboard with a bounded wait.
      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         #3;
         wait_cycles++;
      end
      check("drain_empty", 16'(q.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
